dvi_timing_ctrl: RTL

DVI_TIMING_CTRL -- requirements
Module: dvi_timing_ctrl

---
 rtl/dvi_timing_ctrl_if.sv | 37 +++
 rtl/dvi_timing_ctrl.sv | 133 +++++++++++++
 2 files changed

// File: rtl/dvi_timing_ctrl_if.sv
// Signal bundle between dvi_timing_ctrl (master) and its encoder/fetch consumers (slave).
// With TIMING_TEST_PATTERN_EN defined the bundle also carries the tp_r/tp_g/tp_b colour-bar channels.
interface dvi_timing_ctrl_if;
  logic        en;
  logic        de;
  logic        hsync;
  logic        vsync;
  logic [12:0] x;
  logic [12:0] y;
  logic        pix_req;
  logic        frame_start;
  logic        busy;
  logic [1:0]  state_dbg;
`ifdef TIMING_TEST_PATTERN_EN
  logic [7:0]  tp_r;
  logic [7:0]  tp_g;
  logic [7:0]  tp_b;
`endif

  // pix_req is a fetch strobe with no back-pressure: upstream must have the pixel ready on the
  // next cycle, when de is high for it. en is a level request; busy reports that it is being served.
  modport master (
    input  en,
    output de, hsync, vsync, x, y, pix_req, frame_start, busy, state_dbg
`ifdef TIMING_TEST_PATTERN_EN
    , output tp_r, tp_g, tp_b
`endif
  );

  modport slave (
    output en,
    input  de, hsync, vsync, x, y, pix_req, frame_start, busy, state_dbg
`ifdef TIMING_TEST_PATTERN_EN
    , input tp_r, tp_g, tp_b
`endif
  );
endinterface

// File: rtl/dvi_timing_ctrl.sv
// DVI/VGA raster timing generator with IDLE/RUN/STOPPING control; all outputs registered.
// Optional colour-bar generator enabled by defining TIMING_TEST_PATTERN_EN.
module dvi_timing_ctrl #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter bit SYNC_POL = 1'b0
) (
  input  logic               pix_clk,
  input  logic               rst_n,
  dvi_timing_ctrl_if.master  bus
);
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam logic [12:0] HT_M1    = 13'(H_TOTAL - 1);
  localparam logic [12:0] VT_M1    = 13'(V_TOTAL - 1);
  localparam logic [12:0] HA       = 13'(H_ACTIVE);
  localparam logic [12:0] VA       = 13'(V_ACTIVE);
  localparam logic [12:0] HS_START = 13'(H_ACTIVE + H_FP);
  localparam logic [12:0] HS_END   = 13'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [12:0] VS_START = 13'(V_ACTIVE + V_FP);
  localparam logic [12:0] VS_END   = 13'(V_ACTIVE + V_FP + V_SYNC);

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, STOPPING = 2'd2} state_t;

  state_t      state, state_nx;
  logic [12:0] x_q, y_q, x_inc, y_inc, x_nx, y_nx, x_nn, y_nn;
  logic        frame_end, act_nx;
  logic        de_q, hs_q, vs_q, pr_q, fs_q, busy_q;
  logic        de_d, hs_d, vs_d, pr_d, fs_d;
`ifdef TIMING_TEST_PATTERN_EN
  localparam int BAR_W = H_ACTIVE / 8;
  localparam logic [12:0] B1 = 13'(BAR_W),     B2 = 13'(2 * BAR_W), B3 = 13'(3 * BAR_W);
  localparam logic [12:0] B4 = 13'(4 * BAR_W), B5 = 13'(5 * BAR_W), B6 = 13'(6 * BAR_W);
  localparam logic [12:0] B7 = 13'(7 * BAR_W);
  logic [7:0] tp_r_q, tp_g_q, tp_b_q, tp_r_d, tp_g_d, tp_b_d;
`endif

  // State and registered outputs; the *_d values already describe the cycle being entered.
  always_ff @(posedge pix_clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      x_q    <= '0;
      y_q    <= '0;
      de_q   <= 1'b0;
      hs_q   <= ~SYNC_POL;
      vs_q   <= ~SYNC_POL;
      pr_q   <= 1'b0;
      fs_q   <= 1'b0;
      busy_q <= 1'b0;
`ifdef TIMING_TEST_PATTERN_EN
      tp_r_q <= '0;
      tp_g_q <= '0;
      tp_b_q <= '0;
`endif
    end else begin
      state  <= state_nx;
      x_q    <= x_nx;
      y_q    <= y_nx;
      de_q   <= de_d;
      hs_q   <= hs_d;
      vs_q   <= vs_d;
      pr_q   <= pr_d;
      fs_q   <= fs_d;
      busy_q <= act_nx;
`ifdef TIMING_TEST_PATTERN_EN
      tp_r_q <= tp_r_d;
      tp_g_q <= tp_g_d;
      tp_b_q <= tp_b_d;
`endif
    end
  end

  // Next state and next raster position. A STOPPING frame only ends at its last pixel.
  always_comb begin
    frame_end = (x_q == HT_M1) && (y_q == VT_M1);
    x_inc     = (x_q == HT_M1) ? 13'd0 : x_q + 13'd1;
    y_inc     = (x_q != HT_M1) ? y_q : ((y_q == VT_M1) ? 13'd0 : y_q + 13'd1);
    state_nx  = state;
    case (state)
      IDLE:     if (bus.en) state_nx = RUN;
      RUN:      if (!bus.en) state_nx = STOPPING;
      STOPPING: begin
        if (bus.en)         state_nx = RUN;
        else if (frame_end) state_nx = IDLE;
      end
      default:  state_nx = IDLE;
    endcase
    act_nx = (state_nx != IDLE);
    x_nx   = (state != IDLE && act_nx) ? x_inc : 13'd0;
    y_nx   = (state != IDLE && act_nx) ? y_inc : 13'd0;
  end

  // Output values for the cycle at (x_nx, y_nx); pix_req looks one further pixel ahead.
  always_comb begin
    x_nn = (x_nx == HT_M1) ? 13'd0 : x_nx + 13'd1;
    y_nn = (x_nx != HT_M1) ? y_nx : ((y_nx == VT_M1) ? 13'd0 : y_nx + 13'd1);
    de_d = act_nx && (x_nx < HA) && (y_nx < VA);
    hs_d = (act_nx && (x_nx >= HS_START) && (x_nx < HS_END)) ? SYNC_POL : ~SYNC_POL;
    vs_d = (act_nx && (y_nx >= VS_START) && (y_nx < VS_END)) ? SYNC_POL : ~SYNC_POL;
    fs_d = act_nx && (x_nx == 13'd0) && (y_nx == 13'd0);
    // Only a RUN last pixel guarantees the next frame, so only then is its first pixel fetched.
    pr_d = act_nx && (x_nn < HA) && (y_nn < VA)
         && !((x_nx == HT_M1) && (y_nx == VT_M1) && (state_nx != RUN));
`ifdef TIMING_TEST_PATTERN_EN
    tp_r_d = (de_d && ((x_nx < B2) || ((x_nx >= B4) && (x_nx < B6)))) ? 8'hFF : 8'h00;
    tp_g_d = (de_d && (x_nx < B4)) ? 8'hFF : 8'h00;
    tp_b_d = (de_d && ((x_nx < B1) || ((x_nx >= B2) && (x_nx < B3))
                    || ((x_nx >= B4) && (x_nx < B5)) || ((x_nx >= B6) && (x_nx < B7))))
             ? 8'hFF : 8'h00;
`endif
  end

  assign bus.de          = de_q;
  assign bus.hsync       = hs_q;
  assign bus.vsync       = vs_q;
  assign bus.x           = x_q;
  assign bus.y           = y_q;
  assign bus.pix_req     = pr_q;
  assign bus.frame_start = fs_q;
  assign bus.busy        = busy_q;
  assign bus.state_dbg   = state;
`ifdef TIMING_TEST_PATTERN_EN
  assign bus.tp_r = tp_r_q;
  assign bus.tp_g = tp_g_q;
  assign bus.tp_b = tp_b_q;
`endif
endmodule
